// File: rtl/burst_replay_buffer.sv
// Burst capture into a single-port RAM, then forward or reverse replay over a
// valid/ready handshake. A two-entry output queue (head + skid) absorbs
// in-flight RAM reads so stalls lose nothing and ready-high runs bubble-free.
module burst_replay_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              mode_rev,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PLAY    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
    logic                rev_q, rev_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic                rd_vld_q, rd_vld_d;
    logic                rd_last_q, rd_last_d;
    logic                h_v_q, h_v_d;
    logic                h_last_q, h_last_d;
    logic [DATA_W-1:0]   h_data_q, h_data_d;
    logic                s_v_q, s_v_d;
    logic                s_last_q, s_last_d;
    logic [DATA_W-1:0]   s_data_q, s_data_d;

    logic                ram_we;
    logic                ram_re;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   rd_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                pop;
    logic [2:0]          lvl;

    // Next-state, RAM control and output-queue update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_idx_d  = rd_idx_q;
        rev_d     = rev_q;
        ovf_d     = ovf_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = in_data;
        rd_last_d = 1'b0;

        pop = h_v_q & out_ready;
        // Words that could still land in the queue if another read is issued now
        lvl = 3'(h_v_q) + 3'(s_v_q) + 3'(rd_vld_q) - 3'(pop);

        // Pop moves skid into head, then any returning RAM word fills the first free slot
        h_v_d    = h_v_q;
        h_last_d = h_last_q;
        h_data_d = h_data_q;
        s_v_d    = s_v_q;
        s_last_d = s_last_q;
        s_data_d = s_data_q;
        if (pop) begin
            h_v_d    = s_v_q;
            h_last_d = s_last_q;
            h_data_d = s_data_q;
            s_v_d    = 1'b0;
            s_last_d = 1'b0;
            s_data_d = '0;
        end
        if (rd_vld_q) begin
            if (!h_v_d) begin
                h_v_d    = 1'b1;
                h_last_d = rd_last_q;
                h_data_d = rd_q;
            end else begin
                s_v_d    = 1'b1;
                s_last_d = rd_last_q;
                s_data_d = rd_q;
            end
        end
        if (!h_v_d) begin
            h_last_d = 1'b0;
            h_data_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ram_we   = 1'b1;
                    ram_addr = '0;
                    cnt_d    = CNT_W'(1);
                    rev_d    = mode_rev;
                    ovf_d    = 1'b0;
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    if (cnt_q < DEPTH_C) begin
                        ram_we   = 1'b1;
                        ram_addr = ADDR_W'(cnt_q);
                        cnt_d    = cnt_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    rd_idx_d = '0;
                    state_d  = PLAY;
                end
            end
            PLAY: begin
                if ((rd_idx_q != cnt_q) && (lvl <= 3'd1)) begin
                    ram_re    = 1'b1;
                    ram_addr  = rev_q ? ADDR_W'(cnt_q - CNT_W'(1) - rd_idx_q)
                                      : ADDR_W'(rd_idx_q);
                    rd_last_d = (rd_idx_q == (cnt_q - CNT_W'(1)));
                    rd_idx_d  = rd_idx_q + CNT_W'(1);
                end
                if (pop && h_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_vld_d = ram_re;
        busy_d   = (state_d != IDLE);
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_idx_q  <= '0;
            rev_q     <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            h_v_q     <= 1'b0;
            h_last_q  <= 1'b0;
            h_data_q  <= '0;
            s_v_q     <= 1'b0;
            s_last_q  <= 1'b0;
            s_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_idx_q  <= rd_idx_d;
            rev_q     <= rev_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
            h_v_q     <= h_v_d;
            h_last_q  <= h_last_d;
            h_data_q  <= h_data_d;
            s_v_q     <= s_v_d;
            s_last_q  <= s_last_d;
            s_data_q  <= s_data_d;
        end
    end

    // Single-port RAM: one access per cycle, registered read data
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end else if (ram_re) begin
            rd_q <= mem[ram_addr];
        end
    end

    assign out_valid = h_v_q;
    assign out_data  = h_data_q;
    assign out_last  = h_last_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_burst_replay_buffer.sv
// Scoreboard bench for burst_replay_buffer (DEPTH=8 instance).
module tb_burst_replay_buffer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              mode_rev;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              overflow;
    logic              busy;

    burst_replay_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .mode_rev (mode_rev),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .overflow (overflow),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt  = 0;
    int bp_idx   = 0;
    bit bp_en    = 1'b0;
    bit rdy_lvl  = 1'b1;
    bit mon_en   = 1'b0;
    logic [5:0] bp_pat = 6'b101001;

    logic [16:0] sb[$];
    logic [15:0] w[16];

    bit          prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Ready driver: held level or the 1,0,0,1,0,1 backpressure pattern
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            out_ready = bp_pat[bp_idx];
            bp_idx    = (bp_idx == 5) ? 0 : bp_idx + 1;
        end else begin
            out_ready = rdy_lvl;
        end
    end

    // Output monitor: scoreboard compare on accept, stability while stalled
    always @(negedge clk) begin
        if (mon_en) begin
            if (!out_valid)
                check_eq("idle_data", 32'(out_data), 32'd0);
            if (prev_stall) begin
                check_eq("stall_valid", 32'(out_valid), 32'd1);
                check_eq("stall_data", 32'(out_data), 32'(prev_data));
                check_eq("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
                end else begin
                    logic [16:0] e;
                    e = sb.pop_front();
                    check_eq("data", 32'(out_data), 32'(e[15:0]));
                    check_eq("last", 32'(out_last), 32'(e[16]));
                end
                acc_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_burst(input bit rev, input int n);
        int kept;
        kept = (n > int'(DEPTH)) ? int'(DEPTH) : n;
        if (!rev) begin
            for (int i = 0; i < kept; i++) sb.push_back({(i == kept - 1), w[i]});
        end else begin
            for (int i = kept - 1; i >= 0; i--) sb.push_back({(i == 0), w[i]});
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = w[i];
            mode_rev = rev;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && !out_valid) break;
        end
        check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
        check_eq({tag, "_valid_end"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_last_end"}, 32'(out_last), 32'd0);
        check_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int base;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        mode_rev = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_last", 32'(out_last), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Forward 3 words with latency check
        w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
        send_burst(1'b0, 3);
        @(posedge clk);
        @(negedge clk);
        check_eq("fwd_lat_t0", 32'(out_valid), 32'd0);
        check_eq("fwd_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_eq("fwd_lat_t1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("fwd_lat_t2", 32'(out_valid), 32'd1);
        check_eq("fwd_first", 32'(out_data), 32'h1111);
        @(negedge clk);
        check_eq("fwd_second", 32'(out_data), 32'h2222);
        @(negedge clk);
        check_eq("fwd_third", 32'(out_data), 32'h3333);
        check_eq("fwd_third_last", 32'(out_last), 32'd1);
        wait_idle("fwd");

        // Reverse 3 words
        send_burst(1'b1, 3);
        wait_idle("rev");
        check_eq("rev_ovf", 32'(overflow), 32'd0);

        // Backpressure, with in_valid noise during PLAY that must be ignored
        w[0] = 16'h00A0; w[1] = 16'h00A1; w[2] = 16'h00A2; w[3] = 16'h00A3;
        bp_en = 1'b1;
        send_burst(1'b0, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        wait_idle("bp");
        bp_en = 1'b0;

        // Overflow: 10 words into DEPTH=8
        for (int i = 0; i < 10; i++) w[i] = 16'(i);
        send_burst(1'b0, 10);
        @(posedge clk);
        @(negedge clk);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        wait_idle("ovf");
        check_eq("ovf_hold", 32'(overflow), 32'd1);
        w[0] = 16'h0042; w[1] = 16'h0043;
        send_burst(1'b0, 2);
        wait_idle("ovf_clr");
        check_eq("ovf_cleared", 32'(overflow), 32'd0);

        // Single word reverse
        w[0] = 16'hBEEF;
        send_burst(1'b1, 1);
        wait_idle("single");

        // Reset in the middle of PLAY
        for (int i = 0; i < 5; i++) w[i] = 16'h0C00 + 16'(i);
        base = acc_cnt;
        send_burst(1'b0, 5);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (acc_cnt - base >= 2) break;
        end
        check_eq("mid_accepts", 32'(acc_cnt - base >= 2), 32'd1);
        mon_en  = 1'b0;
        rst_n   = 1'b0;
        rdy_lvl = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_data", 32'(out_data), 32'd0);
        check_eq("mid_rst_last", 32'(out_last), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        mon_en  = 1'b1;
        rdy_lvl = 1'b1;
        w[0] = 16'h0005; w[1] = 16'h0006;
        send_burst(1'b0, 2);
        wait_idle("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
